sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port 256x32 SRAM macro (active-low CEB/WEB/BWEB, 1-cycle read) between two requesters.
//  Uses round-robin arbitration and registers every macro input.
//  Returns read data tagged with the requester id.
//  Drives macro light-sleep (SLP) after an idle period, and enforces a wake-up delay before the next access.
//  Sits between the DRBE compute tiles and the SRAM macro instance.
// PARAMETERS
//  AW        8   address width (macro A)
//  DW        32  data width (macro D/Q)
//  IDLE_SLP  16  consecutive idle cycles before SLP asserts (>=1)
//  WAKE_CYC  2   cycles SLP must be low before the first access after sleep (>=1)
// PORTS
//  CLK        in   1    clock, rising edge
//  RST        in   1    asynchronous reset, active-high
//  req_valid  in   2    per-requester request valid
//  req_ready  out  2    per-requester accept; transfer = valid&ready
//  req_we     in   2    1=write, 0=read (index i for requester i)
//  req_addr   in   2*AW requester i address at [i*AW +: AW]
//  req_wdata  in   2*DW requester i write data
//  req_wmask  in   2*DW/8 byte enables, 1=write byte
//  rsp_valid  out  1    one-cycle pulse, read data valid
//  rsp_id     out  1    requester owning rsp_rdata
//  rsp_rdata  out  DW   registered read data
//  sram_ceb   out  1    macro CEB (active low)
//  sram_web   out  1    macro WEB (0=write)
//  sram_a     out  AW   macro A
//  sram_d     out  DW   macro D
//  sram_bweb  out  DW   macro BWEB (0=bit written)
//  sram_slp   out  1    macro SLP
//  sram_q     in   DW   macro Q
//  busy       out  1    any access in flight or wake pending
// BEHAVIOUR
//  Reset values:
//   - sram_ceb=1, sram_web=1, sram_bweb=all 1, sram_a=0, sram_d=0, sram_slp=0.
//   - req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0.
//   - rr_ptr=0, idle_cnt=0, state=ACTIVE.
//  Macro BIST/AWT/SD/*M pins are tied off at integration; not driven here.
//  FSM states: ACTIVE, SLEEP, WAKE.
//   - ACTIVE: at most one grant per cycle. req_ready is combinational: one-hot to the winner, only in ACTIVE.
//   - Round-robin: rr_ptr names the preferred requester. Grant to rr_ptr if it is valid, else to the other.
//   - After any grant, rr_ptr <= ~granted id.
//  Accept at edge k (transfer cycle k-1):
//   - Edge k registers ceb=0, web=~we, a, d, bweb = ~(wmask expanded bytewise).
//   - The macro samples these at edge k+1.
//   - ceb returns to 1 at edge k+1 unless a new grant occurs (back-to-back, 1 access/cycle).
//  Reads:
//   - Q is valid after edge k+1 and is captured into rsp_rdata at edge k+2.
//   - rsp_valid=1 and rsp_id=id during the cycle after edge k+2.
//   - Load-to-use is 3 edges; no response backpressure.
//  Writes produce no response. Read after write to the same address returns the new data (macro order preserved).
//  Idle counting:
//   - idle_cnt increments in ACTIVE on cycles with no req_valid and no access in flight.
//   - idle_cnt clears on any req_valid.
//   - When idle_cnt reaches IDLE_SLP-1, go to SLEEP and set sram_slp=1 (ceb already 1).
//  SLEEP:
//   - req_ready=0. Any req_valid -> WAKE with sram_slp=0 and wake_cnt=0.
//  WAKE:
//   - req_ready=0; wake_cnt counts to WAKE_CYC-1, then go to ACTIVE. Requests held meanwhile are served normally.
//  Simultaneous valid on both requesters: the winner is served and the loser gets the next cycle.
//  A requester holding valid stalls at most 1 cycle while ACTIVE.
//  Req_valid that drops before being accepted is legal; nothing is issued.
//  Reset mid-access forces all outputs to their reset values immediately. The pending read response is discarded.
//  busy = (state!=ACTIVE) | any ceb-issued/read-capture stage occupied.
// TESTING
//  1. Write-then-read: r0 writes A=0x19, D=0x00000056, mask=4'hF; then r0 reads A=0x19.
//     -> sram_ceb/web low one cycle; rsp_valid at edge k+2, rsp_id=0, rsp_rdata=0x56.
//  2. Byte mask: write 0xFFFFFFFF to A=0x05, then write 0x12345678 with mask=4'b0101, then read.
//     -> sram_bweb=0xFF00FF00 on the second write; rdata=0xFF34FF78.
//  3. Contention: both valid every cycle, reads of A=1 (r0) and A=2 (r1) from reset.
//     -> grants alternate r0,r1,r0,...; rsp_id alternates; ceb low continuously.
//  4. Sleep/wake with IDLE_SLP=16, WAKE_CYC=2: idle 16 cycles, then r1 reads.
//     -> sram_slp=1 after 16 idle cycles; slp=0 on the request; req_ready[1] asserts 2 cycles later.
//  5. Reset mid-read: assert RST the cycle after a read accept.
//     -> sram_ceb=1, rsp_valid stays 0, state ACTIVE, rr_ptr=0 after release.
//  6. Back-to-back writes A=0..255 by r0 followed by a read sweep.
//     -> one access per cycle, address wraps 0xFF->0x00; all data match.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin front end for a single-port SRAM macro with light-sleep control.
// Every macro pin is driven from a flop; read data returns tagged with the requester id.
`timescale 1ns/1ps
module sram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int IDLE_SLP = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  input  logic [2*DW/8-1:0] req_wmask,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DW-1:0]     rsp_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [AW-1:0]     sram_a,
  output logic [DW-1:0]     sram_d,
  output logic [DW-1:0]     sram_bweb,
  output logic              sram_slp,
  input  logic [DW-1:0]     sram_q,
  output logic              busy
);
  localparam int MW  = DW / 8;
  localparam int ICW = (IDLE_SLP > 1) ? $clog2(IDLE_SLP) : 1;
  localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_SLP - 1);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_e;

  function automatic logic [DW-1:0] expand_mask(input logic [MW-1:0] m);
    logic [DW-1:0] e;
    for (int b = 0; b < MW; b++) e[b*8 +: 8] = {8{m[b]}};
    return e;
  endfunction

  state_e         state_q, state_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
  logic           ceb_q, ceb_d, web_q, web_d, slp_q, slp_d;
  logic [AW-1:0]  a_q, a_d;
  logic [DW-1:0]  d_q, d_d, bweb_q, bweb_d;
  logic           rd1_q, rd1_d, id1_q, id1_d, rd2_q, rd2_d, id2_q, id2_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic           grant_vld, grant_id, sel_we, in_flight;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [MW-1:0]  sel_wmask;

  // Round-robin pick: preferred requester first, otherwise the other one.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == ACTIVE) begin
      if (req_valid[rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_id  = rr_ptr_q;
      end else if (req_valid[~rr_ptr_q]) begin
        grant_vld = 1'b1;
        grant_id  = ~rr_ptr_q;
      end
    end
  end

  assign req_ready = (grant_vld && !RST) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign sel_we    = grant_id ? req_we[1] : req_we[0];
  assign sel_addr  = grant_id ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign sel_wdata = grant_id ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
  assign sel_wmask = grant_id ? req_wmask[MW +: MW] : req_wmask[0 +: MW];
  assign in_flight = ~ceb_q | rd2_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    ceb_d       = 1'b1;
    web_d       = 1'b1;
    a_d         = a_q;
    d_d         = d_q;
    bweb_d      = bweb_q;
    slp_d       = slp_q;
    rd1_d       = 1'b0;
    id1_d       = id1_q;
    rd2_d       = rd1_q;
    id2_d       = id1_q;
    rsp_valid_d = rd2_q;
    rsp_id_d    = rd2_q ? id2_q : rsp_id_q;
    rsp_rdata_d = rd2_q ? sram_q : rsp_rdata_q;
    case (state_q)
      ACTIVE: begin
        if (grant_vld) begin
          ceb_d    = 1'b0;
          web_d    = ~sel_we;
          a_d      = sel_addr;
          d_d      = sel_wdata;
          bweb_d   = sel_we ? ~expand_mask(sel_wmask) : '1;
          rd1_d    = ~sel_we;
          id1_d    = grant_id;
          rr_ptr_d = ~grant_id;
        end
        // Idle time only accrues once the macro pipeline has drained.
        if (|req_valid) begin
          idle_cnt_d = '0;
        end else if (!in_flight) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = SLEEP;
            slp_d      = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      SLEEP: begin
        if (|req_valid) begin
          state_d    = WAKE;
          slp_d      = 1'b0;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) state_d = ACTIVE;
        else wake_cnt_d = wake_cnt_q + 1'b1;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACTIVE;
      rr_ptr_q    <= 1'b0;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      ceb_q       <= 1'b1;
      web_q       <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      bweb_q      <= '1;
      slp_q       <= 1'b0;
      rd1_q       <= 1'b0;
      id1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      id2_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      ceb_q       <= ceb_d;
      web_q       <= web_d;
      a_q         <= a_d;
      d_q         <= d_d;
      bweb_q      <= bweb_d;
      slp_q       <= slp_d;
      rd1_q       <= rd1_d;
      id1_q       <= id1_d;
      rd2_q       <= rd2_d;
      id2_q       <= id2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign sram_ceb  = ceb_q;
  assign sram_web  = web_q;
  assign sram_a    = a_q;
  assign sram_d    = d_q;
  assign sram_bweb = bweb_q;
  assign sram_slp  = slp_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != ACTIVE) | in_flight;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM macro, table vectors, corner sequences,
// and random traffic scored against a cycle-level reference of the arbitration/sleep rules.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int IDLE_SLP = 16;
  localparam int WAKE_CYC = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_rdata;
  logic        sram_ceb, sram_web, sram_slp, busy;
  logic [7:0]  sram_a;
  logic [31:0] sram_d, sram_bweb;
  logic [31:0] sram_q = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sram_port_arbiter #(.AW(8), .DW(32), .IDLE_SLP(IDLE_SLP), .WAKE_CYC(WAKE_CYC)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_bweb(sram_bweb), .sram_slp(sram_slp), .sram_q(sram_q), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Macro: samples registered pins on the rising edge, Q valid after that edge.
  logic [31:0] mem [256];
  always @(posedge CLK) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      else sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask32(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Reference model: preferred requester, sleep flag, cycle at which grants resume,
  // golden memory contents and the queue of read responses still owed.
  typedef struct { logic id; logic [31:0] data; int due; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] gold [256];
  bit          m_pref, m_sleep, last_we;
  int          m_idle, m_active_at, last_acc, last_rd;
  logic [7:0]  last_a;
  logic [31:0] last_d, last_bweb;

  always @(negedge CLK) begin : monitor
    logic [1:0]  e_ready;
    bit          gid, e_active, inflight, cebl;
    rsp_t        r;
    logic [7:0]  ga;
    logic [31:0] gm;
    if (RST) begin
      m_pref = 0; m_sleep = 0; m_idle = 0; m_active_at = 0;
      last_acc = -10; last_rd = -10;
      exp_q.delete();
    end else begin
      e_active = !m_sleep && (cyc >= m_active_at);
      e_ready = 2'b00;
      gid = 0;
      if (e_active) begin
        if (req_valid[m_pref]) begin e_ready[m_pref] = 1'b1; gid = m_pref; end
        else if (req_valid[!m_pref]) begin e_ready[!m_pref] = 1'b1; gid = !m_pref; end
      end
      cebl = (last_acc == cyc - 1);
      inflight = cebl || (last_rd == cyc - 2);
      chk("m_ready", 64'(req_ready), 64'(e_ready));
      chk("m_slp", 64'(sram_slp), 64'(m_sleep));
      chk("m_busy", 64'(busy), 64'(!e_active || inflight));
      chk("m_ceb", 64'(sram_ceb), 64'(!cebl));
      chk("m_web", 64'(sram_web), 64'(!(cebl && last_we)));
      if (cebl) begin
        chk("m_addr", 64'(sram_a), 64'(last_a));
        if (last_we) begin
          chk("m_wdata", 64'(sram_d), 64'(last_d));
          chk("m_bweb", 64'(sram_bweb), 64'(last_bweb));
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          r = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(r.id));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
          chk("rsp_latency", 64'(cyc), 64'(r.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("rsp_missing", 64'(rsp_valid), 64'd1);
        r = exp_q.pop_front();
      end
      if (m_sleep) begin
        if (|req_valid) begin
          m_sleep = 0;
          m_active_at = cyc + 1 + WAKE_CYC;
        end
      end else if (e_active) begin
        if (|e_ready) begin
          ga = gid ? req_addr[15:8] : req_addr[7:0];
          last_acc = cyc; last_a = ga; last_we = req_we[gid];
          m_pref = !gid;
          if (req_we[gid]) begin
            gm = mask32(gid ? req_wmask[7:4] : req_wmask[3:0]);
            last_d = gid ? req_wdata[63:32] : req_wdata[31:0];
            last_bweb = ~gm;
            gold[ga] = (gold[ga] & ~gm) | (last_d & gm);
          end else begin
            last_rd = cyc;
            r.id = gid; r.data = gold[ga]; r.due = cyc + 3;
            exp_q.push_back(r);
          end
        end
        if (|req_valid) m_idle = 0;
        else if (!inflight) begin
          m_idle++;
          if (m_idle == IDLE_SLP) begin m_sleep = 1; m_idle = 0; end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] m0, input logic [3:0] m1);
    req_valid = v; req_we = w; req_addr = {a1, a0}; req_wdata = {d1, d0}; req_wmask = {m1, m0};
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  typedef struct {
    logic [1:0] vld, we; logic [7:0] a0; logic [31:0] d0; logic [3:0] m0;
    logic [1:0] e_ready; logic e_ceb, e_web; logic [31:0] e_bweb; logic e_rv; logic [31:0] e_rd;
  } vec_t;
  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idle_run;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; gold[i] = '0; end
    vecs[0]  = '{2'b01, 2'b01, 8'h19, 32'h00000056, 4'hF, 2'b01, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[1]  = '{2'b01, 2'b00, 8'h19, 32'h0,        4'h0, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0};
    vecs[2]  = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[3]  = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[4]  = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000056};
    vecs[5]  = '{2'b01, 2'b01, 8'h05, 32'hFFFFFFFF, 4'hF, 2'b01, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[6]  = '{2'b01, 2'b01, 8'h05, 32'h12345678, 4'h5, 2'b01, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0};
    vecs[7]  = '{2'b01, 2'b00, 8'h05, 32'h0,        4'h0, 2'b01, 1'b0, 1'b0, 32'hFF00FF00, 1'b0, 32'h0};
    vecs[8]  = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[10] = '{2'b00, 2'b00, 8'h00, 32'h0,        4'h0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFF34FF78};

    RST = 1'b1;
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ceb", 64'(sram_ceb), 64'd1);
    chk("rst_web", 64'(sram_web), 64'd1);
    chk("rst_bweb", 64'(sram_bweb), 64'hFFFFFFFF);
    chk("rst_a", 64'(sram_a), 64'd0);
    chk("rst_d", 64'(sram_d), 64'd0);
    chk("rst_slp", 64'(sram_slp), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    next_cycle();
    RST = 1'b0;

    // Write-then-read and byte-mask vectors, one row per cycle.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].vld, vecs[i].we, vecs[i].a0, 8'h00, vecs[i].d0, 32'h0, vecs[i].m0, 4'h0);
      @(negedge CLK);
      chk("tbl_ready", 64'(req_ready), 64'(vecs[i].e_ready));
      chk("tbl_ceb", 64'(sram_ceb), 64'(vecs[i].e_ceb));
      chk("tbl_web", 64'(sram_web), 64'(vecs[i].e_web));
      if (!vecs[i].e_ceb) chk("tbl_bweb", 64'(sram_bweb), 64'(vecs[i].e_bweb));
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk("tbl_rsp_id", 64'(rsp_id), 64'd0);
        chk("tbl_rdata", 64'(rsp_rdata), 64'(vecs[i].e_rd));
      end
      next_cycle();
    end

    // Contention from reset: grants alternate and the macro is busy every cycle.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      drive(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 4'h0, 4'h0);
      @(negedge CLK);
      chk("cont_ready", 64'(req_ready), (j % 2) ? 64'd2 : 64'd1);
      if (j > 0) chk("cont_ceb", 64'(sram_ceb), 64'd0);
      next_cycle();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (5) next_cycle();

    // Sleep after IDLE_SLP idle cycles, then wake on a request from r1.
    do_reset();
    for (int j = 0; j < 19; j++) begin
      @(negedge CLK);
      chk("slp_level", 64'(sram_slp), (j >= IDLE_SLP) ? 64'd1 : 64'd0);
      next_cycle();
    end
    drive(2'b10, 2'b00, 8'h0, 8'h19, 32'h0, 32'h0, 4'h0, 4'h0);
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk("wake_ready", 64'(req_ready), (j == 3) ? 64'd2 : 64'd0);
      if (j > 0) chk("wake_slp", 64'(sram_slp), 64'd0);
      next_cycle();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (5) next_cycle();

    // Reset the cycle after a read accept: nothing may come back.
    drive(2'b01, 2'b00, 8'h19, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    @(negedge CLK);
    chk("rstmid_accept", 64'(req_ready), 64'd1);
    next_cycle();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmid_ceb", 64'(sram_ceb), 64'd1);
    chk("rstmid_rsp", 64'(rsp_valid), 64'd0);
    next_cycle();
    next_cycle();
    RST = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      next_cycle();
    end
    drive(2'b11, 2'b00, 8'h01, 8'h02, 32'h0, 32'h0, 4'h0, 4'h0);
    @(negedge CLK);
    chk("rstmid_rrptr", 64'(req_ready), 64'd1);
    next_cycle();
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (5) next_cycle();

    // Back-to-back full-range writes, then a read sweep crossing 0xFF -> 0x00.
    for (int i = 0; i < 256; i++) begin
      drive(2'b01, 2'b01, 8'(i), 8'h0, (32'(i) * 32'h01000193) ^ 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
      @(negedge CLK);
      chk("sweep_wr_ready", 64'(req_ready), 64'd1);
      next_cycle();
    end
    for (int i = 0; i < 256; i++) begin
      drive(2'b01, 2'b00, 8'(i + 128), 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      @(negedge CLK);
      chk("sweep_rd_ready", 64'(req_ready), 64'd1);
      next_cycle();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (5) next_cycle();

    // Random traffic on a small address window, with occasional long idle runs.
    idle_run = 0;
    for (int n = 0; n < 3000; n++) begin
      if (idle_run > 0) begin
        idle_run--;
        drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      end else begin
        if ($urandom_range(0, 99) < 3) idle_run = $urandom_range(10, 30);
        drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      next_cycle();
    end
    drive(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (10) next_cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
